// File: rtl/pll_reset_pkg.sv
// Shared types and constants for the PLL reset sequencer: the FSM state
// encoding and the width of the relock event counter.
package pll_reset_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  localparam int RELOCK_W = 8;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with synchronous active-high reset, used to
// bring asynchronous status flags into the local clock domain.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_seq.sv
// Holds downstream logic in reset until the PLL lock is stable for LOCK_WAIT
// cycles, then releases it and strobes a divided pixel clock-enable.
module pll_reset_seq
  import pll_reset_pkg::*;
#(
  parameter int LOCK_WAIT   = 1024,
  parameter int LOSS_FILTER = 4,
  parameter int CE_DIV      = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                locked,
  output logic                sys_reset,
  output logic                pix_ce,
  output logic                ready,
  output logic                lock_lost,
  output logic [RELOCK_W-1:0] relock_count
);

  localparam int SETTLE_W = $clog2(LOCK_WAIT) + 1;
  localparam int LOSS_W   = $clog2(LOSS_FILTER) + 1;
  localparam int DIV_W    = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(LOCK_WAIT - 1);
  localparam logic [LOSS_W-1:0]   LOSS_LAST   = LOSS_W'(LOSS_FILTER - 1);
  localparam logic [DIV_W-1:0]    DIV_LAST    = DIV_W'(CE_DIV - 1);

  state_t              state;
  state_t              next_state;
  logic                locked_s;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [SETTLE_W-1:0] settle_next;
  logic [LOSS_W-1:0]   loss_cnt;
  logic [LOSS_W-1:0]   loss_next;
  logic [DIV_W-1:0]    div_cnt;
  logic                lost_event;
  logic                run_hold;
  logic                div_wrap;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clock (clock),
    .reset (reset),
    .d     (locked),
    .q     (locked_s)
  );

  always_comb begin
    next_state  = state;
    settle_next = settle_cnt;
    loss_next   = loss_cnt;
    lost_event  = 1'b0;
    case (state)
      WAIT_LOCK: begin
        settle_next = '0;
        loss_next   = '0;
        if (locked_s) next_state = SETTLE;
      end
      SETTLE: begin
        if (!locked_s) begin
          next_state  = WAIT_LOCK;
          settle_next = '0;
        end else if (settle_cnt == SETTLE_LAST) begin
          next_state  = RUN;
          settle_next = '0;
        end else begin
          settle_next = settle_cnt + 1'b1;
        end
      end
      RUN: begin
        if (locked_s) begin
          loss_next = '0;
        end else if (loss_cnt == LOSS_LAST) begin
          // Only a run of LOSS_FILTER consecutive low samples counts as loss.
          next_state = WAIT_LOCK;
          loss_next  = '0;
          lost_event = 1'b1;
        end else begin
          loss_next = loss_cnt + 1'b1;
        end
      end
      default: begin
        next_state  = WAIT_LOCK;
        settle_next = '0;
        loss_next   = '0;
      end
    endcase
  end

  // The divider only runs while staying in RUN, so pix_ce drops on the exit edge.
  assign run_hold = (state == RUN) && (next_state == RUN);
  assign div_wrap = (div_cnt == DIV_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= WAIT_LOCK;
      settle_cnt   <= '0;
      loss_cnt     <= '0;
      div_cnt      <= '0;
      sys_reset    <= 1'b1;
      ready        <= 1'b0;
      pix_ce       <= 1'b0;
      lock_lost    <= 1'b0;
      relock_count <= '0;
    end else begin
      state      <= next_state;
      settle_cnt <= settle_next;
      loss_cnt   <= loss_next;
      sys_reset  <= (next_state != RUN);
      ready      <= (next_state == RUN);
      if (run_hold) begin
        div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
        pix_ce  <= div_wrap;
      end else begin
        div_cnt <= '0;
        pix_ce  <= 1'b0;
      end
      if (lost_event) begin
        lock_lost <= 1'b1;
        if (relock_count != '1) relock_count <= relock_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq with LOCK_WAIT=16, LOSS_FILTER=4, CE_DIV=2;
// expected timings are hand-derived from the lock/loss latencies.
module tb_pll_reset_seq;

  logic       clock;
  logic       reset;
  logic       locked;
  logic       sys_reset;
  logic       pix_ce;
  logic       ready;
  logic       lock_lost;
  logic [7:0] relock_count;

  int passed;
  int total;

  pll_reset_seq #(
    .LOCK_WAIT   (16),
    .LOSS_FILTER (4),
    .CE_DIV      (2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .locked       (locked),
    .sys_reset    (sys_reset),
    .pix_ce       (pix_ce),
    .ready        (ready),
    .lock_lost    (lock_lost),
    .relock_count (relock_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one edge and sample 1 ns later, away from the active edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    locked = 1'b0;
    repeat (3) tick();
    total++; if (sys_reset !== 1'b1) $display("FAIL reset_sys_reset: got %b expected 1", sys_reset); else passed++;
    total++; if (ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", ready); else passed++;
    total++; if (pix_ce !== 1'b0) $display("FAIL reset_pix_ce: got %b expected 0", pix_ce); else passed++;
    total++; if (lock_lost !== 1'b0) $display("FAIL reset_lock_lost: got %b expected 0", lock_lost); else passed++;
    total++; if (relock_count !== 8'd0) $display("FAIL reset_relock_count: got %0d expected 0", relock_count); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_no_lock();
    int bad;
    bad = 0;
    locked = 1'b0;
    repeat (200) begin
      tick();
      if (sys_reset !== 1'b1 || ready !== 1'b0 || pix_ce !== 1'b0) bad++;
    end
    total++; if (bad !== 0) $display("FAIL no_lock_held: got %0d bad cycles expected 0", bad); else passed++;
  endtask

  // Edge k after setting locked is E0+k-1; release lands on E0+18.
  task automatic test_lock_release();
    int bad;
    bad = 0;
    locked = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (sys_reset !== 1'b1 || ready !== 1'b0) bad++;
    end
    total++; if (bad !== 0) $display("FAIL release_early: got %0d bad cycles expected 0", bad); else passed++;
    tick();
    total++; if (sys_reset !== 1'b0) $display("FAIL release_sys_reset: got %b expected 0", sys_reset); else passed++;
    total++; if (ready !== 1'b1) $display("FAIL release_ready: got %b expected 1", ready); else passed++;
    total++; if (pix_ce !== 1'b0) $display("FAIL release_pix_r0: got %b expected 0", pix_ce); else passed++;
    tick();
    total++; if (pix_ce !== 1'b0) $display("FAIL release_pix_r1: got %b expected 0", pix_ce); else passed++;
    tick();
    total++; if (pix_ce !== 1'b1) $display("FAIL release_pix_r2: got %b expected 1", pix_ce); else passed++;
    tick();
    total++; if (pix_ce !== 1'b0) $display("FAIL release_pix_r3: got %b expected 0", pix_ce); else passed++;
    tick();
    total++; if (pix_ce !== 1'b1) $display("FAIL release_pix_r4: got %b expected 1", pix_ce); else passed++;
  endtask

  task automatic test_glitch();
    int   bad;
    logic prev;
    bad  = 0;
    prev = pix_ce;
    locked = 1'b0;
    for (int k = 0; k < 15; k++) begin
      if (k == 3) locked = 1'b1;
      tick();
      if (sys_reset !== 1'b0 || ready !== 1'b1 || lock_lost !== 1'b0) bad++;
      if (pix_ce !== ~prev) bad++;
      prev = pix_ce;
    end
    total++; if (bad !== 0) $display("FAIL glitch_outputs: got %0d bad samples expected 0", bad); else passed++;
    total++; if (relock_count !== 8'd0) $display("FAIL glitch_relock_count: got %0d expected 0", relock_count); else passed++;
  endtask

  // Falling edge F is the first to sample 0; outputs flip after F+5.
  task automatic test_sustained_loss();
    int bad;
    bad = 0;
    locked = 1'b0;
    repeat (5) tick();
    total++; if (sys_reset !== 1'b0 || ready !== 1'b1) $display("FAIL loss_early: got sys_reset=%b ready=%b expected 0/1", sys_reset, ready); else passed++;
    tick();
    total++; if (sys_reset !== 1'b1) $display("FAIL loss_sys_reset: got %b expected 1", sys_reset); else passed++;
    total++; if (ready !== 1'b0) $display("FAIL loss_ready: got %b expected 0", ready); else passed++;
    total++; if (pix_ce !== 1'b0) $display("FAIL loss_pix_ce: got %b expected 0", pix_ce); else passed++;
    total++; if (lock_lost !== 1'b1) $display("FAIL loss_lock_lost: got %b expected 1", lock_lost); else passed++;
    total++; if (relock_count !== 8'd1) $display("FAIL loss_relock_count: got %0d expected 1", relock_count); else passed++;
    repeat (4) tick();
    locked = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (sys_reset !== 1'b1 || ready !== 1'b0 || pix_ce !== 1'b0) bad++;
    end
    total++; if (bad !== 0) $display("FAIL relock_early: got %0d bad cycles expected 0", bad); else passed++;
    tick();
    total++; if (sys_reset !== 1'b0 || ready !== 1'b1) $display("FAIL relock_release: got sys_reset=%b ready=%b expected 0/1", sys_reset, ready); else passed++;
  endtask

  // Drop lands with settle_cnt at 10; the full count restarts from the new rise.
  task automatic test_settle_glitch();
    int bad;
    bad = 0;
    reset = 1'b1;
    locked = 1'b0;
    tick();
    reset = 1'b0;
    locked = 1'b1;
    repeat (13) tick();
    locked = 1'b0;
    tick();
    locked = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (sys_reset !== 1'b1 || ready !== 1'b0) bad++;
    end
    total++; if (bad !== 0) $display("FAIL settle_restart_early: got %0d bad cycles expected 0", bad); else passed++;
    tick();
    total++; if (sys_reset !== 1'b0 || ready !== 1'b1) $display("FAIL settle_restart_release: got sys_reset=%b ready=%b expected 0/1", sys_reset, ready); else passed++;
    total++; if (lock_lost !== 1'b0) $display("FAIL settle_lock_lost: got %b expected 0", lock_lost); else passed++;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) begin
      locked = 1'b0;
      repeat (6) tick();
      locked = 1'b1;
      repeat (19) tick();
      if (i == 199) begin
        total++; if (relock_count !== 8'd200) $display("FAIL sat_count_200: got %0d expected 200", relock_count); else passed++;
      end
    end
    total++; if (relock_count !== 8'd255) $display("FAIL sat_count_255: got %0d expected 255", relock_count); else passed++;
    total++; if (lock_lost !== 1'b1) $display("FAIL sat_lock_lost: got %b expected 1", lock_lost); else passed++;
    total++; if (sys_reset !== 1'b0 || ready !== 1'b1) $display("FAIL sat_running: got sys_reset=%b ready=%b expected 0/1", sys_reset, ready); else passed++;
  endtask

  task automatic test_reset_mid_run();
    int bad;
    bad = 0;
    reset = 1'b1;
    tick();
    total++; if (sys_reset !== 1'b1) $display("FAIL midrun_sys_reset: got %b expected 1", sys_reset); else passed++;
    total++; if (ready !== 1'b0) $display("FAIL midrun_ready: got %b expected 0", ready); else passed++;
    total++; if (pix_ce !== 1'b0) $display("FAIL midrun_pix_ce: got %b expected 0", pix_ce); else passed++;
    total++; if (lock_lost !== 1'b0) $display("FAIL midrun_lock_lost: got %b expected 0", lock_lost); else passed++;
    total++; if (relock_count !== 8'd0) $display("FAIL midrun_relock_count: got %0d expected 0", relock_count); else passed++;
    reset = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (sys_reset !== 1'b1 || ready !== 1'b0) bad++;
    end
    total++; if (bad !== 0) $display("FAIL post_reset_early: got %0d bad cycles expected 0", bad); else passed++;
    tick();
    total++; if (sys_reset !== 1'b0 || ready !== 1'b1) $display("FAIL post_reset_release: got sys_reset=%b ready=%b expected 0/1", sys_reset, ready); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset  = 1'b1;
    locked = 1'b0;
    test_reset();
    test_no_lock();
    test_lock_release();
    test_glitch();
    test_sustained_loss();
    test_settle_glitch();
    test_saturation();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "[TB] timeout");
  end

endmodule
